// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Operation context captured on accept and used for the final sign fix-up
    typedef struct packed {
        md_op_e op;
        logic   neg_res;
        logic   neg_rem;
    } md_ctl_t;

    function automatic logic is_div(md_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(md_op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic a_signed(md_op_e op);
        return (op != MD_MULHU) && (op != MD_DIVU) && (op != MD_REMU);
    endfunction

    function automatic logic b_signed(md_op_e op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake between the execute stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int unsigned DWIDTH = 32
) ();
    import muldiv_pkg::*;

    logic              in_valid;
    logic              in_ready;
    md_op_e            op;
    logic [DWIDTH-1:0] a;
    logic [DWIDTH-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] result;

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result
    );

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result
    );
endinterface

// File: rtl/muldiv_shift_core.sv
// Shared shift register and adder/subtractor: one shift-add multiply step or one
// restoring-divide step per cycle on unsigned magnitudes.
module muldiv_shift_core #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              div_mode,
    input  logic [DWIDTH-1:0] lo_init,
    input  logic [DWIDTH-1:0] m_init,
    output logic [DWIDTH-1:0] hi_nxt_c,
    output logic [DWIDTH-1:0] lo_nxt_c,
    output logic              last_c
);
    localparam int unsigned CW = $clog2(DWIDTH) + 1;
    localparam int unsigned AW = DWIDTH + 1;

    logic [DWIDTH-1:0] hi_q, lo_q, m_q;
    logic [CW-1:0]     cnt_q;
    logic [AW-1:0]     add_a, add_b;
    logic [AW:0]       sum;

    // Divide subtracts the divisor from the shifted partial remainder; multiply adds the multiplicand
    always_comb begin
        add_a = div_mode ? {hi_q, lo_q[DWIDTH-1]} : {1'b0, hi_q};
        add_b = div_mode ? ~{1'b0, m_q} : {1'b0, m_q};
        sum   = {1'b0, add_a} + {1'b0, add_b} + {{AW{1'b0}}, div_mode};
    end

    always_comb begin
        hi_nxt_c = hi_q;
        lo_nxt_c = lo_q;
        if (div_mode) begin
            if (sum[AW]) begin
                hi_nxt_c = sum[DWIDTH-1:0];
                lo_nxt_c = {lo_q[DWIDTH-2:0], 1'b1};
            end else begin
                hi_nxt_c = add_a[DWIDTH-1:0];
                lo_nxt_c = {lo_q[DWIDTH-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            hi_nxt_c = sum[AW-1:1];
            lo_nxt_c = {sum[0], lo_q[DWIDTH-1:1]};
        end else begin
            hi_nxt_c = {1'b0, hi_q[DWIDTH-1:1]};
            lo_nxt_c = {hi_q[0], lo_q[DWIDTH-1:1]};
        end
        last_c = (cnt_q == CW'(DWIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            hi_q  <= '0;
            lo_q  <= lo_init;
            m_q   <= m_init;
            cnt_q <= '0;
        end else if (step) begin
            hi_q  <= hi_nxt_c;
            lo_q  <= lo_nxt_c;
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, operand capture, fast paths and sign fix-up.
// Define MULDIV_FAST_MUL_EN to compute MUL* with a single-cycle combinational multiplier.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    muldiv_if.slave  bus
);
    localparam int unsigned       PW      = 2 * DWIDTH;
    localparam logic [DWIDTH-1:0] MIN_INT = {1'b1, {(DWIDTH-1){1'b0}}};

    md_state_e         state_q, state_d;
    md_ctl_t           ctl_q, ctl_d;
    logic [DWIDTH-1:0] result_q, result_d;
    logic              in_ready_q, out_valid_q;
    logic              a_neg_c, b_neg_c, ovf_c, fast_c, core_load_c, core_step_c;
    logic [DWIDTH-1:0] mag_a_c, mag_b_c, fast_res_c, calc_res_c;
    logic [DWIDTH-1:0] hi_nxt_c, lo_nxt_c;
    logic              last_c;

    // Selects the MUL/MULH* half after restoring the sign of the magnitude product
    function automatic logic [DWIDTH-1:0] mul_pick(logic [PW-1:0] prod, logic neg, md_op_e op);
        logic [PW-1:0] p;
        p = neg ? -prod : prod;
        return (op == MD_MUL) ? p[DWIDTH-1:0] : p[PW-1:DWIDTH];
    endfunction

    always_comb begin
        a_neg_c = a_signed(bus.op) & bus.a[DWIDTH-1];
        b_neg_c = b_signed(bus.op) & bus.b[DWIDTH-1];
        mag_a_c = a_neg_c ? -bus.a : bus.a;
        mag_b_c = b_neg_c ? -bus.b : bus.b;
        ovf_c   = ((bus.op == MD_DIV) || (bus.op == MD_REM)) && (bus.a == MIN_INT) && (&bus.b);
    end

    // Results that need no iteration are resolved directly on the accept edge
    always_comb begin
        fast_c     = 1'b0;
        fast_res_c = '0;
        if (is_div(bus.op)) begin
            if (bus.b == '0) begin
                fast_c     = 1'b1;
                fast_res_c = is_rem(bus.op) ? bus.a : '1;
            end else if (ovf_c) begin
                fast_c     = 1'b1;
                fast_res_c = is_rem(bus.op) ? '0 : bus.a;
            end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            fast_c     = 1'b1;
            fast_res_c = mul_pick(PW'(mag_a_c) * PW'(mag_b_c), a_neg_c ^ b_neg_c, bus.op);
`else
            if ((bus.a == '0) || (bus.b == '0)) begin
                fast_c     = 1'b1;
                fast_res_c = '0;
            end
`endif
        end
    end

    always_comb begin
        calc_res_c = mul_pick({hi_nxt_c, lo_nxt_c}, ctl_q.neg_res, ctl_q.op);
        if (is_div(ctl_q.op)) begin
            if (is_rem(ctl_q.op)) calc_res_c = ctl_q.neg_rem ? -hi_nxt_c : hi_nxt_c;
            else                  calc_res_c = ctl_q.neg_res ? -lo_nxt_c : lo_nxt_c;
        end
    end

    muldiv_shift_core #(.DWIDTH(DWIDTH)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load_c),
        .step     (core_step_c),
        .div_mode (is_div(ctl_q.op)),
        .lo_init  (is_div(bus.op) ? mag_a_c : mag_b_c),
        .m_init   (is_div(bus.op) ? mag_b_c : mag_a_c),
        .hi_nxt_c (hi_nxt_c),
        .lo_nxt_c (lo_nxt_c),
        .last_c   (last_c)
    );

    always_comb begin
        state_d     = state_q;
        ctl_d       = ctl_q;
        result_d    = result_q;
        core_load_c = 1'b0;
        core_step_c = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (bus.in_valid) begin
                    ctl_d.op      = bus.op;
                    ctl_d.neg_res = a_neg_c ^ b_neg_c;
                    ctl_d.neg_rem = a_neg_c;
                    if (fast_c) begin
                        result_d = fast_res_c;
                        state_d  = MD_DONE;
                    end else begin
                        core_load_c = 1'b1;
                        state_d     = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                core_step_c = 1'b1;
                if (last_c) begin
                    result_d = calc_res_c;
                    state_d  = MD_DONE;
                end
            end
            MD_DONE: begin
                if (bus.out_ready) state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MD_IDLE;
            ctl_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctl_q       <= ctl_d;
            result_q    <= result_d;
            in_ready_q  <= (state_d == MD_IDLE);
            out_valid_q <= (state_d == MD_DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, handshake corner cases,
// and randomised operations against a signed-arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MLAT = 1;
`else
    localparam int MLAT = W + 1;
`endif
    localparam int DLAT = W + 1;

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[18];

    muldiv_if #(.DWIDTH(W)) bus ();

    muldiv_unit #(.DWIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics computed with 64-bit arithmetic
    function automatic logic [31:0] ref_md(md_op_e op, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic [31:0]        r;
        r = '0;
        case (op)
            MD_MUL: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r  = sp[31:0];
            end
            MD_MULH: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r  = sp[63:32];
            end
            MD_MULHSU: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
                r  = sp[63:32];
            end
            MD_MULHU: begin
                up = {32'b0, a} * {32'b0, b};
                r  = up[63:32];
            end
            MD_DIV: begin
                if (b == 0) r = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = $signed(a) / $signed(b);
            end
            MD_REM: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                else r = $signed(a) % $signed(b);
            end
            MD_DIVU: r = (b == 0) ? '1 : a / b;
            MD_REMU: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int exp_latency(md_op_e op, logic [31:0] a, logic [31:0] b);
        if (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) begin
            if (b == 0) return 1;
            if ((op inside {MD_DIV, MD_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return DLAT;
        end
        if (a == 0 || b == 0) return 1;
        return MLAT;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issues one request, scrambles the inputs after accept, checks latency and result, then drains
    task automatic do_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat_exp, input string tag,
                         input int gap_in, input int gap_out);
        int budget;
        int lat;
        repeat (gap_in) @(negedge clk);
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        budget = 0;
        while (!bus.in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.in_ready) begin
            check($sformatf("%s accept", tag), 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = md_op_e'($urandom_range(0, 7));
        bus.a  = $urandom;
        bus.b  = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 100);
        check($sformatf("%s latency", tag), 32'(lat), 32'(lat_exp));
        check($sformatf("%s result", tag), bus.result, exp);
        repeat (gap_out) @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        md_op_e      rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MLAT};
        vecs[1]  = '{MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MLAT};
        vecs[2]  = '{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MLAT};
        vecs[3]  = '{MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MLAT};
        vecs[4]  = '{MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DLAT};
        vecs[5]  = '{MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DLAT};
        vecs[6]  = '{MD_DIVU,   32'hFFFF_FFFE,  32'd2,         32'h7FFF_FFFF, DLAT};
        vecs[7]  = '{MD_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[8]  = '{MD_REMU,   32'd5,          32'd0,         32'd5,         1};
        vecs[9]  = '{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[10] = '{MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[11] = '{MD_MUL,    32'd0,          32'h1234_5678, 32'd0,         1};
        vecs[12] = '{MD_MULHU,  32'h1234_5678,  32'd0,         32'd0,         1};
        vecs[13] = '{MD_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, DLAT};
        vecs[14] = '{MD_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         DLAT};
        vecs[15] = '{MD_DIVU,   32'd100,        32'd7,         32'd14,        DLAT};
        vecs[16] = '{MD_REMU,   32'd100,        32'd7,         32'd2,         DLAT};
        vecs[17] = '{MD_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         DLAT};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = MD_MUL; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result", bus.result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 18; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                  $sformatf("vec%0d", i), 0, 0);

        // Backpressure: a pending request must wait through DONE and the DONE->IDLE cycle
        @(negedge clk);
        bus.op = MD_DIVU; bus.a = 32'd1000; bus.b = 32'd3; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.op = MD_REMU; bus.a = 32'd77; bus.b = 32'd5;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 100);
        check("bp latency", 32'(lat), 32'(DLAT));
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp%0d result", i), bus.result, 32'd333);
            check($sformatf("bp%0d in_ready", i), 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp release out_valid", 32'(bus.out_valid), 32'd0);
        check("bp release in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 100);
        check("bp next latency", 32'(lat), 32'(DLAT));
        check("bp next result", bus.result, 32'd2);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;

        // Reset in the middle of an iterative divide aborts it
        @(negedge clk);
        bus.op = MD_DIV; bus.a = 32'd100; bus.b = 32'd7; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mid-calc in_ready", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(MD_DIV, 32'd100, 32'd7, 32'd14, DLAT, "after abort", 0, 0);

        for (int i = 0; i < 1000; i++) begin
            rop = md_op_e'($urandom_range(0, 7));
            ra  = rnd_operand();
            rb  = rnd_operand();
            do_op(rop, ra, rb, ref_md(rop, ra, rb), exp_latency(rop, ra, rb),
                  $sformatf("rnd%0d op%0d a=%08h b=%08h", i, rop, ra, rb),
                  $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
